// File: rtl/ones_detect_ctrl_pkg.sv
// Shared types and width helpers for the time-shared ones-count detector.
// Build option: ONES_DETECT_EARLY_EXIT_EN (see ones_detect_ctrl).
package ones_detect_pkg;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  function automatic int cnt_w(int width);
    return $clog2(width + 1);
  endfunction

  function automatic int id_w(int nreq);
    return (nreq < 2) ? 1 : $clog2(nreq);
  endfunction

  // Widths for the default 9-bit, 2-requester configuration.
  localparam int CNT_W = cnt_w(9);
  localparam int ID_W  = id_w(2);

endpackage

// File: rtl/ones_detect_ctrl_if.sv
// Request/response bundle between requesters and the ones-count engine.
interface ones_detect_if
  import ones_detect_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int NREQ  = 2
) ();

  logic [NREQ-1:0]         req_valid;
  logic [NREQ*WIDTH-1:0]   req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [id_w(NREQ)-1:0]   resp_id;
  logic [cnt_w(WIDTH)-1:0] resp_count;
  logic                    resp_hit;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_count, resp_hit
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_id, resp_count, resp_hit
  );

endinterface

// File: rtl/ones_detect_ctrl_rr_arbiter.sv
// Combinational round-robin grant; the search starts just after 'last',
// whose register lives in the parent.
module rr_arbiter
  import ones_detect_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] grant
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ones_detect_ctrl.sv
// Round-robin sequencer for one bit-serial ones counter shared by NREQ requesters.
// Build option: ONES_DETECT_EARLY_EXIT_EN stops counting once the target is exceeded.
//
//   state | meaning
//   IDLE  | arbitrating, req_ready driven from the round-robin grant
//   COUNT | shifting the latched vector, one bit per cycle
//   DONE  | result held on resp_* until resp_ready
module ones_detect_ctrl
  import ones_detect_pkg::*;
#(
  parameter int WIDTH      = 9,
  parameter int NREQ       = 2,
  parameter int DEF_TARGET = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [cnt_w(WIDTH)-1:0] cfg_target,
  ones_detect_if.slave            bus,
  output logic                    busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam int IW = id_w(NREQ);

  state_t           state;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    bitcnt_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    target_q;
  logic [CW-1:0]    cmp_q;
  logic [IW-1:0]    id_q;
  logic [IW-1:0]    last_q;
  logic             resp_valid_q;
  logic [CW-1:0]    resp_count_q;
  logic             resp_hit_q;
  logic             busy_q;

  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    gid;
  logic [WIDTH-1:0] sel_data;
  logic             accept;
  logic [CW-1:0]    count_nxt;
  logic             early;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req   (bus.req_valid),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    gid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) gid = IW'(i);
    end
  end

  // Grant is masked during reset so nothing is accepted on a reset edge.
  assign bus.req_ready = (state == IDLE && !reset) ? grant : '0;
  assign accept        = |(bus.req_valid & bus.req_ready);
  assign sel_data      = bus.req_data[int'(gid)*WIDTH +: WIDTH];
  assign count_nxt     = count_q + CW'(shift_q[0]);

`ifdef ONES_DETECT_EARLY_EXIT_EN
  assign early = (count_nxt > cmp_q);
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      shift_q      <= '0;
      bitcnt_q     <= '0;
      count_q      <= '0;
      target_q     <= CW'(DEF_TARGET);
      cmp_q        <= '0;
      id_q         <= '0;
      last_q       <= IW'(NREQ - 1);
      resp_valid_q <= 1'b0;
      resp_count_q <= '0;
      resp_hit_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      if (cfg_we) target_q <= cfg_target;
      case (state)
        IDLE: begin
          if (accept) begin
            shift_q  <= sel_data;
            cmp_q    <= target_q;
            id_q     <= gid;
            last_q   <= gid;
            count_q  <= '0;
            bitcnt_q <= CW'(WIDTH);
            busy_q   <= 1'b1;
            state    <= COUNT;
          end
        end
        COUNT: begin
          count_q  <= count_nxt;
          shift_q  <= shift_q >> 1;
          bitcnt_q <= bitcnt_q - CW'(1);
          if (bitcnt_q == CW'(1) || early) begin
            resp_valid_q <= 1'b1;
            resp_count_q <= count_nxt;
            resp_hit_q   <= (count_nxt == cmp_q);
            state        <= DONE;
          end
        end
        DONE: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = id_q;
  assign bus.resp_count = resp_count_q;
  assign bus.resp_hit   = resp_hit_q;
  assign busy           = busy_q;

endmodule
